// File: rtl/video_pack_in.sv
// video_pack_in: packs PIX_BITS pixels into OUT_BITS words for the DDR write FIFO
// and runs the per-frame control handshake. Optional: `VPACK_FRAME_ERR_EN adds frame_err detection.
module video_pack_in #(
  parameter int ADDR_BITS   = 25,
  parameter int PIX_BITS    = 32,
  parameter int OUT_BITS    = 64,
  parameter int LOAD_CYCLES = 5
) (
  input  logic                 pclk,
  input  logic                 prst,
  input  logic                 vsync,
  input  logic                 de,
  input  logic [PIX_BITS-1:0]  indata,
  input  logic [ADDR_BITS-1:0] baseaddr,
  input  logic [23:0]          video_width,
  input  logic [11:0]          video_height,
  input  logic                 fifo_full,
  output logic                 wr_fifo_en,
  output logic [OUT_BITS-1:0]  wr_data,
  output logic                 arst_fifo,
  output logic                 loadbase,
  output logic [ADDR_BITS-1:0] ddr_baseaddr,
  output logic [23:0]          ddr_line_length,
  output logic [11:0]          ddr_col_length,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 frame_err
);

  localparam int PPW  = OUT_BITS / PIX_BITS;
  localparam int LN_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int LC_W = $clog2(LOAD_CYCLES + 1);
  localparam logic [LN_W-1:0] LN_LAST   = LN_W'(PPW - 1);
  localparam logic [LC_W-1:0] LOAD_LAST = LC_W'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE, S_FEND} state_t;

  state_t                state_q, state_d;
  logic [LC_W-1:0]       load_cnt_q, load_cnt_d;
  logic                  vsync_q;
  logic [ADDR_BITS-1:0]  base_q, base_d;
  logic [23:0]           width_q, width_d;
  logic [11:0]           height_q, height_d;
  logic [23:0]           line_len_q, line_len_d;
  logic [23:0]           pc_q, pc_d;
  logic [LN_W-1:0]       ln_q, ln_d;
  logic [11:0]           lc_q, lc_d;
  logic [OUT_BITS-1:0]   acc_q, acc_d;
  logic                  wr_en_q, wr_en_d;
  logic [OUT_BITS-1:0]   wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic                  vs_rise, vs_fall;
  logic                  line_end, word_close;
  logic [OUT_BITS-1:0]   word_c;
  logic [23:0]           line_len_c;

  assign vs_rise    = vsync & ~vsync_q;
  assign vs_fall    = ~vsync & vsync_q;
  assign line_len_c = (video_width + 24'(PPW - 1)) / 24'(PPW);

  // Current accumulator with the incoming pixel dropped into lane ln; lane 0 is the MSB lane.
  always_comb begin
    word_c = acc_q;
    for (int k = 0; k < PPW; k++) begin
      if (ln_q == LN_W'(k)) word_c[OUT_BITS-1-k*PIX_BITS -: PIX_BITS] = indata;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    base_d     = base_q;
    width_d    = width_q;
    height_d   = height_q;
    line_len_d = line_len_q;
    pc_d       = pc_q;
    ln_d       = ln_q;
    lc_d       = lc_q;
    acc_d      = acc_q;
    wr_en_d    = 1'b0;
    wr_data_d  = '0;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    line_end   = 1'b0;
    word_close = 1'b0;

    if (vs_rise) begin
      state_d = S_IDLE;
      acc_d   = '0;
    end else if (vs_fall) begin
      base_d     = baseaddr;
      width_d    = video_width;
      height_d   = video_height;
      line_len_d = line_len_c;
      load_cnt_d = '0;
      state_d    = S_LOAD;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_LOAD: begin
          pc_d  = '0;
          ln_d  = '0;
          lc_d  = '0;
          acc_d = '0;
          ovf_d = 1'b0;
          if (load_cnt_q == LOAD_LAST) begin
            if (width_q == 24'd0 || height_q == 12'd0) begin
              state_d = S_FEND;
              done_d  = 1'b1;
            end else begin
              state_d = S_ACTIVE;
            end
          end else begin
            load_cnt_d = load_cnt_q + LC_W'(1);
          end
        end
        S_ACTIVE: begin
          if (de) begin
            line_end   = (pc_q == width_q - 24'd1);
            word_close = (ln_q == LN_LAST) || line_end;
            if (word_close) begin
              // A full FIFO drops the word but the counters still advance to keep line alignment.
              ln_d  = '0;
              acc_d = '0;
              if (fifo_full) begin
                ovf_d = 1'b1;
              end else begin
                wr_en_d   = 1'b1;
                wr_data_d = word_c;
              end
            end else begin
              ln_d  = ln_q + LN_W'(1);
              acc_d = word_c;
            end
            if (line_end) begin
              pc_d = '0;
              lc_d = lc_q + 12'd1;
              if (lc_q == height_q - 12'd1) begin
                state_d = S_FEND;
                done_d  = 1'b1;
              end
            end else begin
              pc_d = pc_q + 24'd1;
            end
          end
        end
        S_FEND: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the partial-word
  // accumulator is reset as well so no stale pixels can leak into a word after prst.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      vsync_q    <= 1'b0;
      base_q     <= '0;
      width_q    <= '0;
      height_q   <= '0;
      line_len_q <= '0;
      pc_q       <= '0;
      ln_q       <= '0;
      lc_q       <= '0;
      acc_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      vsync_q    <= vsync;
      base_q     <= base_d;
      width_q    <= width_d;
      height_q   <= height_d;
      line_len_q <= line_len_d;
      pc_q       <= pc_d;
      ln_q       <= ln_d;
      lc_q       <= lc_d;
      acc_q      <= acc_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef VPACK_FRAME_ERR_EN
  // Short frame: vsync rises mid-frame. Long frame: pixels arrive after the frame completed.
  logic ferr_q;
  always_ff @(posedge pclk) begin
    if (prst) begin
      ferr_q <= 1'b0;
    end else if (vs_rise) begin
      if (state_q == S_ACTIVE) ferr_q <= 1'b1;
    end else if (!vs_fall) begin
      if (state_q == S_LOAD) ferr_q <= 1'b0;
      else if (state_q == S_FEND && de) ferr_q <= 1'b1;
    end
  end
  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

  assign wr_fifo_en      = wr_en_q;
  assign wr_data         = wr_data_q;
  assign frame_done      = done_q;
  assign overflow        = ovf_q;
  assign arst_fifo       = (state_q == S_LOAD);
  assign loadbase        = (state_q == S_LOAD) && (load_cnt_q == '0);
  assign ddr_baseaddr    = base_q;
  assign ddr_line_length = line_len_q;
  assign ddr_col_length  = height_q;

endmodule

// File: tb/tb_video_pack_in.sv
// Testbench for video_pack_in: three instances (8/16/32-bit pixels into 64-bit words)
// share one stimulus stream and are compared every cycle against a frame-level reference model.
module tb_video_pack_in;

  localparam int OB = 64;
  localparam int LC = 5;
  localparam bit FERR_EN =
`ifdef VPACK_FRAME_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  logic        pclk = 1'b0;
  logic        prst, vsync, de, fifo_full;
  logic [31:0] pix_in;
  logic [24:0] baseaddr;
  logic [23:0] video_width;
  logic [11:0] video_height;

  logic        en_o   [3];
  logic [63:0] data_o [3];
  logic        arst_o [3];
  logic        lb_o   [3];
  logic        done_o [3];
  logic        ovf_o  [3];
  logic        ferr_o [3];
  logic [24:0] base_o [3];
  logic [23:0] ll_o   [3];
  logic [11:0] cl_o   [3];

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int PB = 8 << g;
    video_pack_in #(.ADDR_BITS(25), .PIX_BITS(PB), .OUT_BITS(OB), .LOAD_CYCLES(LC)) u_dut (
      .pclk(pclk), .prst(prst), .vsync(vsync), .de(de), .indata(pix_in[PB-1:0]),
      .baseaddr(baseaddr), .video_width(video_width), .video_height(video_height),
      .fifo_full(fifo_full), .wr_fifo_en(en_o[g]), .wr_data(data_o[g]),
      .arst_fifo(arst_o[g]), .loadbase(lb_o[g]), .ddr_baseaddr(base_o[g]),
      .ddr_line_length(ll_o[g]), .ddr_col_length(cl_o[g]), .frame_done(done_o[g]),
      .overflow(ovf_o[g]), .frame_err(ferr_o[g])
    );
  end

  // ---------------- reference model (frame-level view) ----------------
  typedef enum {M_IDLE, M_LOAD, M_ACT, M_FEND} mph_t;
  int          PBW [3] = '{8, 16, 32};
  mph_t        ph;
  int          load_k;
  logic        vs_prev;
  logic [24:0] m_base;
  logic [23:0] m_w;
  logic [11:0] m_h;
  longint      n_pix;
  logic [31:0] pixq[$];
  int          wcnt  [3];
  logic        e_en  [3];
  logic [63:0] e_data[3];
  logic        e_ovf [3];
  logic        e_done, e_ferr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int cnt16  = 0;

  function automatic logic [63:0] pack(input int c, input int cnt);
    logic [63:0] word = '0;
    logic [63:0] mask = (64'd1 << PBW[c]) - 64'd1;
    for (int j = 0; j < cnt; j++) begin
      logic [63:0] px = 64'(pixq[pixq.size() - cnt + j]) & mask;
      word |= px << (OB - PBW[c] * (j + 1));
    end
    return word;
  endfunction

  task automatic model_step();
    logic rise, fall;
    longint x;
    e_done = 1'b0;
    for (int c = 0; c < 3; c++) begin e_en[c] = 1'b0; e_data[c] = '0; end
    if (prst) begin
      ph = M_IDLE; load_k = 0; vs_prev = 1'b0; m_base = '0; m_w = '0; m_h = '0;
      n_pix = 0; pixq.delete(); e_ferr = 1'b0;
      for (int c = 0; c < 3; c++) begin wcnt[c] = 0; e_ovf[c] = 1'b0; end
      return;
    end
    rise = vsync & ~vs_prev;
    fall = ~vsync & vs_prev;
    if (rise) begin
      if (ph == M_ACT) e_ferr = 1'b1;
      ph = M_IDLE;
    end else if (fall) begin
      m_base = baseaddr; m_w = video_width; m_h = video_height;
      ph = M_LOAD; load_k = 0;
    end else begin
      case (ph)
        M_LOAD: begin
          e_ferr = 1'b0; n_pix = 0; pixq.delete();
          for (int c = 0; c < 3; c++) begin wcnt[c] = 0; e_ovf[c] = 1'b0; end
          if (load_k == LC - 1) begin
            if (m_w == 0 || m_h == 0) begin ph = M_FEND; e_done = 1'b1; end
            else ph = M_ACT;
          end else load_k++;
        end
        M_ACT: if (de) begin
          pixq.push_back(pix_in);
          x = n_pix % longint'(m_w);
          for (int c = 0; c < 3; c++) begin
            wcnt[c]++;
            if (wcnt[c] == OB / PBW[c] || x == longint'(m_w) - 1) begin
              if (fifo_full) e_ovf[c] = 1'b1;
              else begin e_en[c] = 1'b1; e_data[c] = pack(c, wcnt[c]); end
              wcnt[c] = 0;
            end
          end
          n_pix++;
          if (n_pix == longint'(m_w) * longint'(m_h)) begin ph = M_FEND; e_done = 1'b1; end
        end
        M_FEND: if (de) e_ferr = 1'b1;
        default: ;
      endcase
    end
    vs_prev = vsync;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < 3; c++) begin
      int ppw = OB / PBW[c];
      int ll  = (int'(m_w) + ppw - 1) / ppw;
      chk($sformatf("wr_fifo_en[%0d]@%0d", c, cyc), 64'(en_o[c]), 64'(e_en[c]));
      chk($sformatf("wr_data[%0d]@%0d", c, cyc), data_o[c], e_data[c]);
      chk($sformatf("frame_done[%0d]@%0d", c, cyc), 64'(done_o[c]), 64'(e_done));
      chk($sformatf("overflow[%0d]@%0d", c, cyc), 64'(ovf_o[c]), 64'(e_ovf[c]));
      chk($sformatf("frame_err[%0d]@%0d", c, cyc), 64'(ferr_o[c]), 64'(e_ferr & FERR_EN));
      chk($sformatf("arst_fifo[%0d]@%0d", c, cyc), 64'(arst_o[c]), 64'(ph == M_LOAD));
      chk($sformatf("loadbase[%0d]@%0d", c, cyc), 64'(lb_o[c]), 64'(ph == M_LOAD && load_k == 0));
      chk($sformatf("ddr_baseaddr[%0d]@%0d", c, cyc), 64'(base_o[c]), 64'(m_base));
      chk($sformatf("ddr_line_length[%0d]@%0d", c, cyc), 64'(ll_o[c]), 64'(ll));
      chk($sformatf("ddr_col_length[%0d]@%0d", c, cyc), 64'(cl_o[c]), 64'(m_h));
    end
  endtask

  task automatic step(input logic v, input logic d, input logic [31:0] p, input logic f);
    vsync = v; de = d; pix_in = p; fifo_full = f;
    model_step();
    @(posedge pclk);
    #1;
    cyc++;
    if (en_o[1] === 1'b1) cnt16++;
    compare_all();
  endtask

  // One frame: vsync pulse, fall with geometry, LOAD with random de, then pixels.
  // stop_after >= 0 ends the pixel phase early; full_at forces fifo_full on that pixel.
  task automatic run_frame(input logic [24:0] b, input int w, input int h, input int full_at,
                           input int full_pct, input int stop_after, input bit toggle, input int extra);
    int pcount = 0;
    int guard  = 0;
    int tgt    = (stop_after >= 0) ? stop_after : w * h;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    baseaddr = b; video_width = 24'(w); video_height = 12'(h);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (LC) step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
    if (w == 0 || h == 0) tgt = 0;
    while (pcount < tgt && guard < 4000) begin
      logic d = toggle ? (guard % 2 == 0) : ($urandom_range(0, 99) < 70);
      logic f = (d && pcount == full_at) ? 1'b1 : ($urandom_range(0, 99) < full_pct);
      step(1'b0, d, $urandom, f);
      if (d) pcount++;
      guard++;
    end
    repeat (extra) step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
  endtask

  initial begin
    prst = 1'b1; vsync = 1'b0; de = 1'b0; fifo_full = 1'b0; pix_in = '0;
    baseaddr = '0; video_width = '0; video_height = '0;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    prst = 1'b0;

    // 16-bit pixels, width 10 x 2 lines: six strobes, partial words zero-padded
    cnt16 = 0;
    run_frame(25'h1A0000, 10, 2, -1, 0, -1, 1'b0, 3);
    chk("t1_strobes16", 64'(cnt16), 64'd6);
    chk("t3_baseaddr", 64'(base_o[0]), 64'h1A0000);

    // de toggling every cycle, width 4 x 1 line
    run_frame(25'h0000400, 4, 1, -1, 0, -1, 1'b1, 2);

    // fifo_full on the closing pixel of the second 8-bit word
    run_frame(25'h0123456, 16, 2, 15, 0, -1, 1'b0, 2);
    chk("t4_overflow8", 64'(ovf_o[0]), 64'd1);

    // prst mid-line, then pixels without a new vsync fall must produce nothing
    run_frame(25'h0000800, 12, 2, -1, 0, 5, 1'b0, 0);
    prst = 1'b1;
    step(1'b0, 1'b1, $urandom, 1'b0);
    prst = 1'b0;
    repeat (12) step(1'b0, 1'b1, $urandom, 1'b0);

    // short frame: vsync rises after one of two lines, frame_err clears at the next LOAD
    run_frame(25'h0001000, 3, 2, -1, 0, 3, 1'b0, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t6_frame_err", 64'(ferr_o[1]), 64'(FERR_EN));
    run_frame(25'h0002000, 3, 2, -1, 0, -1, 1'b0, 0);
    chk("t6_frame_err_clear", 64'(ferr_o[1]), 64'd0);

    // randomized frames: geometry incl. zero, early vsync, backpressure, trailing de
    repeat (14) begin
      int w  = int'($urandom_range(0, 20));
      int h  = int'($urandom_range(0, 3));
      int sa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, w * h)) : -1;
      run_frame(25'($urandom), w, h, -1, 15, sa, 1'b0, int'($urandom_range(0, 4)));
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
